// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits LSB first,
// odd parity, stop, then wait for the device ACK. Pads are driven through low-enables.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned FRAME_TIMEOUT  = 100000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       txBusy,
    output logic       txDone,
    output logic       txError,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkOe,
    output logic       ps2DataOe
);

    localparam int unsigned FiltW  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TimerW = 20;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StInhibit = 3'd1;
    localparam logic [2:0] StRts     = 3'd2;
    localparam logic [2:0] StWait1   = 3'd3;
    localparam logic [2:0] StData    = 3'd4;
    localparam logic [2:0] StAckWait = 3'd5;
    localparam logic [2:0] StDone    = 3'd6;
    localparam logic [2:0] StError   = 3'd7;

    logic [1:0]        clk_sync_q, data_sync_q;
    logic              clk_s, data_s;
    logic              filt_q, filt_d;
    logic [FiltW-1:0]  filt_cnt_q, filt_cnt_d;
    logic              fall;

    logic [2:0]        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d, timer_inc;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              parity_q, parity_d;
    logic              data_oe_q, data_oe_d;

    // Pads idle high, so the synchronisers and the filter come out of reset at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2ClkIn};
            data_sync_q <= {data_sync_q[0], ps2DataIn};
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // A new clock level is accepted only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall       = 1'b0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
                fall   = ~clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        tx_data_d = tx_data_q;
        parity_d  = parity_q;
        data_oe_d = data_oe_q;
        case (state_q)
            StIdle: begin
                data_oe_d = 1'b0;
                if (txStart) begin
                    tx_data_d = txData;
                    parity_d  = ~^txData;
                    timer_d   = '0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                timer_d = timer_inc;
                if (timer_inc >= TimerW'(INHIBIT_CYCLES)) begin
                    timer_d   = '0;
                    data_oe_d = 1'b1;
                    state_d   = StRts;
                end
            end
            StRts: begin
                timer_d = '0;
                state_d = StWait1;
            end
            StWait1: begin
                timer_d = timer_inc;
                if (fall) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else if (timer_inc >= TimerW'(START_TIMEOUT)) begin
                    data_oe_d = 1'b0;
                    state_d   = StError;
                end
            end
            StData: begin
                timer_d = timer_inc;
                if (timer_inc >= TimerW'(FRAME_TIMEOUT)) begin
                    data_oe_d = 1'b0;
                    state_d   = StError;
                end else if (fall) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q < 4'd8) begin
                        data_oe_d = ~tx_data_q[bit_idx_q[2:0]];
                    end else if (bit_idx_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else if (bit_idx_q == 4'd9) begin
                        data_oe_d = 1'b0;
                    end else begin
                        // Eleventh edge: device must be pulling data low as its ACK.
                        bit_idx_d = bit_idx_q;
                        data_oe_d = 1'b0;
                        state_d   = data_s ? StError : StAckWait;
                    end
                end
            end
            StAckWait: begin
                timer_d = timer_inc;
                if (timer_inc >= TimerW'(FRAME_TIMEOUT)) begin
                    state_d = StError;
                end else if (filt_q && data_s) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                data_oe_d = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            bit_idx_q <= '0;
            tx_data_q <= '0;
            parity_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            tx_data_q <= tx_data_d;
            parity_q  <= parity_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign txBusy    = (state_q != StIdle);
    assign txDone    = (state_q == StDone);
    assign txError   = (state_q == StError);
    assign ps2ClkOe  = (state_q == StInhibit) || (state_q == StRts);
    assign ps2DataOe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple clocking PS/2 device model on the pads.
module tb_ps2_host_tx;

    localparam int unsigned Inhibit  = 50;
    localparam int unsigned StartTo  = 600;
    localparam int unsigned FrameTo  = 1500;
    localparam int          Half     = 25;

    logic       clk, rst;
    logic [7:0] txData;
    logic       txStart;
    logic       txBusy, txDone, txError;
    logic       ps2ClkIn, ps2DataIn, ps2ClkOe, ps2DataOe;
    logic       dev_clk_low, dev_data_low, glitch_low;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    logic [1:0] err_oe = 2'b11;

    assign ps2ClkIn  = ~(ps2ClkOe | dev_clk_low | glitch_low);
    assign ps2DataIn = ~(ps2DataOe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inhibit),
        .START_TIMEOUT (StartTo),
        .FRAME_TIMEOUT (FrameTo),
        .FILTER_LEN    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .txData   (txData),
        .txStart  (txStart),
        .txBusy   (txBusy),
        .txDone   (txDone),
        .txError  (txError),
        .ps2ClkIn (ps2ClkIn),
        .ps2DataIn(ps2DataIn),
        .ps2ClkOe (ps2ClkOe),
        .ps2DataOe(ps2DataOe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (txDone) done_cnt <= done_cnt + 1;
            if (txError) begin
                err_cnt <= err_cnt + 1;
                err_oe  <= {ps2ClkOe, ps2DataOe};
            end
            if (txDone && txError) both_cnt <= both_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        txData  = b;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        check("accept_busy", {31'd0, txBusy}, 32'd1);
    endtask

    // Returns on the first sampled cycle with clock released and start bit driven.
    task automatic wait_release(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!ps2ClkOe && ps2DataOe) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (!txBusy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Device clocks nclk pulses and samples data just before each rising edge.
    task automatic dev_clock(input int nclk, input bit ack, output logic [10:0] bits);
        bits = '0;
        step(30);
        for (int i = 1; i <= nclk; i++) begin
            if (i == 12 && ack) begin
                dev_data_low = 1'b1;
                step(5);
            end
            dev_clk_low = 1'b1;
            step(Half);
            if (i <= 11) bits[i-1] = ps2DataIn;
            dev_clk_low = 1'b0;
            step(Half);
        end
        if (ack) begin
            step(5);
            dev_data_low = 1'b0;
        end
    endtask

    initial begin
        logic [10:0] bits;
        bit ok;
        int d0, e0, n;

        rst = 1'b0; txData = '0; txStart = 1'b0;
        dev_clk_low = 1'b0; dev_data_low = 1'b0; glitch_low = 1'b0;
        step(3);
        check("rst_busy",  {31'd0, txBusy},    32'd0);
        check("rst_done",  {31'd0, txDone},    32'd0);
        check("rst_err",   {31'd0, txError},   32'd0);
        check("rst_clkoe", {31'd0, ps2ClkOe},  32'd0);
        check("rst_datoe", {31'd0, ps2DataOe}, 32'd0);
        rst = 1'b1;
        step(3);

        // 1: 0xF4 with ACK
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hF4);
        step(2);
        check("inhibit_clkoe", {31'd0, ps2ClkOe}, 32'd1);
        wait_release(ok);
        check("t1_rts", {31'd0, ok}, 32'd1);
        dev_clock(12, 1'b1, bits);
        wait_idle(ok);
        check("t1_idle", {31'd0, ok}, 32'd1);
        check("t1_bits", {21'd0, bits}, 32'h5E8);
        check("t1_done", done_cnt - d0, 32'd1);
        check("t1_err",  err_cnt - e0, 32'd0);

        // 2: 0xED, parity 1
        d0 = done_cnt;
        start_tx(8'hED);
        wait_release(ok);
        dev_clock(12, 1'b1, bits);
        wait_idle(ok);
        check("t2_bits",   {21'd0, bits}, 32'h7DA);
        check("t2_parity", {31'd0, bits[9]}, 32'd1);
        check("t2_done",   done_cnt - d0, 32'd1);

        // 3: no ACK
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hF4);
        wait_release(ok);
        dev_clock(12, 1'b0, bits);
        wait_idle(ok);
        check("t3_idle",   {31'd0, ok}, 32'd1);
        check("t3_err",    err_cnt - e0, 32'd1);
        check("t3_done",   done_cnt - d0, 32'd0);
        check("t3_err_oe", {30'd0, err_oe}, 32'd0);

        // 4: device never clocks
        e0 = err_cnt;
        start_tx(8'h3C);
        wait_release(ok);
        n = 0;
        while (!txError && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("t4_timeout", n, StartTo);
        @(negedge clk);
        check("t4_pulse", {31'd0, txError}, 32'd0);
        check("t4_busy",  {31'd0, txBusy},  32'd0);
        check("t4_err",   err_cnt - e0, 32'd1);

        // 5: reset mid-frame, then 0x55
        start_tx(8'h00);
        wait_release(ok);
        dev_clock(5, 1'b0, bits);
        check("t5_pre_doe", {31'd0, ps2DataOe}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("t5_rst_clkoe", {31'd0, ps2ClkOe},  32'd0);
        check("t5_rst_datoe", {31'd0, ps2DataOe}, 32'd0);
        check("t5_rst_busy",  {31'd0, txBusy},    32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(20);
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h55);
        wait_release(ok);
        dev_clock(12, 1'b1, bits);
        wait_idle(ok);
        check("t5_bits", {21'd0, bits}, 32'h6AA);
        check("t5_done", done_cnt - d0, 32'd1);
        check("t5_err",  err_cnt - e0, 32'd0);

        // 6: glitch in WAIT1 and txStart while busy
        d0 = done_cnt;
        start_tx(8'h12);
        wait_release(ok);
        step(5);
        glitch_low = 1'b1;
        step(3);
        glitch_low = 1'b0;
        txData  = 8'hAA;
        txStart = 1'b1;
        step(1);
        txStart = 1'b0;
        dev_clock(12, 1'b1, bits);
        wait_idle(ok);
        check("t6_bits", {21'd0, bits}, 32'h624);
        check("t6_done", done_cnt - d0, 32'd1);
        step(200);
        check("t6_no_second", {31'd0, txBusy}, 32'd0);
        check("t6_done_once", done_cnt - d0, 32'd1);
        check("never_both",   both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
